// File: rtl/fp_issue_queue.sv
// In-order three-operand issue queue between FP register read and the FPU.
// Optional macro FPQ_BYPASS_EN: an enqueue into an idle, empty queue loads the issue register directly.
module fp_issue_queue #(
    parameter int DEPTH = 4,
    parameter int FLEN  = 32,
    parameter int TAG_W = 5
) (
    input  logic                   clk,
    input  logic                   resetn,
    input  logic                   flush,
    input  logic                   enq_valid,
    output logic                   enq_ready,
    input  logic [31:0]            enq_instr,
    input  logic [FLEN-1:0]        enq_rs1,
    input  logic [FLEN-1:0]        enq_rs2,
    input  logic [FLEN-1:0]        enq_rs3,
    input  logic [TAG_W-1:0]       enq_tag,
    input  logic [2:0]             frm,
    output logic                   iss_valid,
    output logic                   iss_start,
    output logic [31:0]            iss_instr,
    output logic [FLEN-1:0]        iss_rs1,
    output logic [FLEN-1:0]        iss_rs2,
    output logic [FLEN-1:0]        iss_rs3,
    output logic [TAG_W-1:0]       iss_tag,
    output logic [2:0]             iss_rm,
    input  logic                   fpu_done,
    output logic [$clog2(DEPTH):0] count,
    output logic [0:0]             dbg_state
);

    // Handshakes: an enqueue happens on a cycle with enq_valid & enq_ready & !flush;
    // enq_ready depends only on registered occupancy. The FPU retires the issued
    // instruction with a single-cycle fpu_done while iss_valid is high.

    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;
    localparam logic [CW-1:0] FULL = CW'(DEPTH);

    localparam logic [0:0] ST_IDLE = 1'b0;
    localparam logic [0:0] ST_BUSY = 1'b1;

    logic [0:0]       state_q, state_d;
    logic [PW-1:0]    head_q, tail_q;
    logic [CW-1:0]    count_q;

    logic [31:0]      mem_instr [DEPTH];
    logic [FLEN-1:0]  mem_rs1   [DEPTH];
    logic [FLEN-1:0]  mem_rs2   [DEPTH];
    logic [FLEN-1:0]  mem_rs3   [DEPTH];
    logic [TAG_W-1:0] mem_tag   [DEPTH];

    logic             enq_fire, bypass, push, pop, load;
    logic [31:0]      ld_instr;
    logic [FLEN-1:0]  ld_rs1, ld_rs2, ld_rs3;
    logic [TAG_W-1:0] ld_tag;

    // Dynamic rounding mode (funct3 == 111) takes frm as sampled at the load edge.
    function automatic logic [2:0] resolve_rm(input logic [31:0] instr, input logic [2:0] dyn);
        return (instr[14:12] == 3'b111) ? dyn : instr[14:12];
    endfunction

    assign enq_ready = (count_q != FULL);
    assign count     = count_q;
    assign iss_valid = (state_q == ST_BUSY);
    assign dbg_state = state_q;

    always_comb begin
        enq_fire = enq_valid & enq_ready & ~flush;
`ifdef FPQ_BYPASS_EN
        bypass   = enq_fire & (state_q == ST_IDLE) & (count_q == '0);
`else
        bypass   = 1'b0;
`endif
        pop      = ~flush & (count_q != '0) & ((state_q == ST_IDLE) | fpu_done);
        push     = enq_fire & ~bypass;
        load     = pop | bypass;
    end

    always_comb begin
        ld_instr = mem_instr[head_q];
        ld_rs1   = mem_rs1[head_q];
        ld_rs2   = mem_rs2[head_q];
        ld_rs3   = mem_rs3[head_q];
        ld_tag   = mem_tag[head_q];
        if (bypass) begin
            ld_instr = enq_instr;
            ld_rs1   = enq_rs1;
            ld_rs2   = enq_rs2;
            ld_rs3   = enq_rs3;
            ld_tag   = enq_tag;
        end
    end

    always_comb begin
        state_d = state_q;
        if (flush) begin
            state_d = ST_IDLE;
        end else if (load) begin
            state_d = ST_BUSY;
        end else if ((state_q == ST_BUSY) && fpu_done) begin
            state_d = ST_IDLE;
        end
    end

    always_ff @(posedge clk) begin
        if (!resetn || flush) begin
            state_q <= ST_IDLE;
            head_q  <= '0;
            tail_q  <= '0;
            count_q <= '0;
        end else begin
            state_q <= state_d;
            if (push) tail_q <= tail_q + PW'(1);
            if (pop)  head_q <= head_q + PW'(1);
            if (push && !pop)      count_q <= count_q + CW'(1);
            else if (pop && !push) count_q <= count_q - CW'(1);
        end
    end

    // Storage needs no reset: occupancy alone decides which slots are live.
    always_ff @(posedge clk) begin
        if (push) begin
            mem_instr[tail_q] <= enq_instr;
            mem_rs1[tail_q]   <= enq_rs1;
            mem_rs2[tail_q]   <= enq_rs2;
            mem_rs3[tail_q]   <= enq_rs3;
            mem_tag[tail_q]   <= enq_tag;
        end
    end

    always_ff @(posedge clk) begin
        if (!resetn || flush) begin
            iss_start <= 1'b0;
            iss_instr <= '0;
            iss_rs1   <= '0;
            iss_rs2   <= '0;
            iss_rs3   <= '0;
            iss_tag   <= '0;
            iss_rm    <= '0;
        end else begin
            iss_start <= load;
            if (load) begin
                iss_instr <= ld_instr;
                iss_rs1   <= ld_rs1;
                iss_rs2   <= ld_rs2;
                iss_rs3   <= ld_rs3;
                iss_tag   <= ld_tag;
                iss_rm    <= resolve_rm(ld_instr, frm);
            end
        end
    end

endmodule

// File: tb/tb_fp_issue_queue.sv
// Bench for fp_issue_queue: expected issue words are queued at enqueue and compared at iss_start.
module tb_fp_issue_queue;

    localparam int DEPTH = 4;
    localparam int FLEN  = 32;
    localparam int TAG_W = 5;
    localparam int CW    = $clog2(DEPTH) + 1;
    localparam int W     = 32 + 3 * FLEN + TAG_W + 3;

    localparam logic [31:0] FMUL  = {7'b0001000, 5'd2, 5'd1, 3'b111, 5'd3, 7'b1010011};
    localparam logic [31:0] FMADD = {5'd4, 2'b00, 5'd2, 5'd1, 3'b000, 5'd3, 7'b1000011};

    logic             clk = 1'b0;
    logic             resetn, flush, enq_valid, enq_ready, fpu_done;
    logic [31:0]      enq_instr;
    logic [FLEN-1:0]  enq_rs1, enq_rs2, enq_rs3;
    logic [TAG_W-1:0] enq_tag;
    logic [2:0]       frm;
    logic             iss_valid, iss_start;
    logic [31:0]      iss_instr;
    logic [FLEN-1:0]  iss_rs1, iss_rs2, iss_rs3;
    logic [TAG_W-1:0] iss_tag;
    logic [2:0]       iss_rm;
    logic [CW-1:0]    count;
    logic [0:0]       dbg_state;

    logic [W-1:0] exp_q[$];
    logic [W-1:0] last_iss;
    logic [W-1:0] iss_word;
    logic         mon_en = 1'b0;
    int           checks = 0;
    int           passes = 0;

    assign iss_word = {iss_instr, iss_rs1, iss_rs2, iss_rs3, iss_tag, iss_rm};

    fp_issue_queue #(.DEPTH(DEPTH), .FLEN(FLEN), .TAG_W(TAG_W)) dut (
        .clk(clk), .resetn(resetn), .flush(flush),
        .enq_valid(enq_valid), .enq_ready(enq_ready), .enq_instr(enq_instr),
        .enq_rs1(enq_rs1), .enq_rs2(enq_rs2), .enq_rs3(enq_rs3), .enq_tag(enq_tag),
        .frm(frm), .iss_valid(iss_valid), .iss_start(iss_start), .iss_instr(iss_instr),
        .iss_rs1(iss_rs1), .iss_rs2(iss_rs2), .iss_rs3(iss_rs3), .iss_tag(iss_tag),
        .iss_rm(iss_rm), .fpu_done(fpu_done), .count(count), .dbg_state(dbg_state)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [W-1:0] act, input logic [W-1:0] exp);
        checks++;
        if (act === exp) passes++;
        else $display("FAIL %s: got %0h expected %0h", tag, act, exp);
    endtask

    function automatic logic [2:0] exp_rm(input logic [31:0] instr, input logic [2:0] dyn);
        return (instr[14:12] == 3'b111) ? dyn : instr[14:12];
    endfunction

    // Called at a negedge; returns at the following negedge.
    task automatic step(input logic ev, input logic [31:0] instr, input logic [FLEN-1:0] r1,
                        input logic [FLEN-1:0] r2, input logic [FLEN-1:0] r3,
                        input logic [TAG_W-1:0] tg, input logic done, input logic fl);
        logic acc;
        enq_valid = ev; enq_instr = instr; enq_rs1 = r1; enq_rs2 = r2; enq_rs3 = r3;
        enq_tag = tg; fpu_done = done; flush = fl;
        acc = ev && enq_ready && !fl;
        @(posedge clk);
        if (fl) exp_q.delete();
        if (acc) exp_q.push_back({instr, r1, r2, r3, tg, exp_rm(instr, frm)});
        @(negedge clk);
        enq_valid = 1'b0; fpu_done = 1'b0; flush = 1'b0;
    endtask

    task automatic idle(input logic done);
        step(1'b0, 32'h0, '0, '0, '0, '0, done, 1'b0);
    endtask

    task automatic enq(input logic [31:0] instr, input logic [FLEN-1:0] r1,
                       input logic [FLEN-1:0] r2, input logic [FLEN-1:0] r3,
                       input logic [TAG_W-1:0] tg);
        step(1'b1, instr, r1, r2, r3, tg, 1'b0, 1'b0);
    endtask

    always @(negedge clk) begin
        if (mon_en) begin
            if (iss_start) begin
                check("start_valid", W'(iss_valid), W'(1));
                if (exp_q.size() == 0) check("unexpected_issue", W'(1), W'(0));
                else check("issue_order", iss_word, exp_q.pop_front());
                last_iss = iss_word;
            end else if (iss_valid) begin
                check("hold", iss_word, last_iss);
            end
            check("count", W'(count), W'(exp_q.size()));
        end
    end

    initial begin
        resetn = 1'b0; flush = 1'b0; enq_valid = 1'b0; fpu_done = 1'b0;
        enq_instr = '0; enq_rs1 = '0; enq_rs2 = '0; enq_rs3 = '0; enq_tag = '0;
        frm = 3'b010;
        repeat (3) @(negedge clk);
        check("rst_ready", W'(enq_ready), W'(1));
        check("rst_count", W'(count), W'(0));
        check("rst_valid", W'(iss_valid), W'(0));
        check("rst_start", W'(iss_start), W'(0));
        check("rst_iss", iss_word, W'(0));
        resetn = 1'b1;
        mon_en = 1'b1;
        @(negedge clk);

        // Single fmul with dynamic rounding.
        enq(FMUL, 32'h40400000, 32'h40000000, 32'h0, 5'd0);
`ifdef FPQ_BYPASS_EN
        check("lat_valid", W'(iss_valid), W'(1));
        check("lat_start", W'(iss_start), W'(1));
        idle(1'b0);
`else
        check("lat_early", W'(iss_valid), W'(0));
        idle(1'b0);
        check("lat_valid", W'(iss_valid), W'(1));
        check("lat_start", W'(iss_start), W'(1));
`endif
        check("fmul_rm", W'(iss_rm), W'(3'b010));
        check("fmul_rs1", W'(iss_rs1), W'(32'h40400000));
        repeat (3) idle(1'b0);
        check("fmul_hold_valid", W'(iss_valid), W'(1));
        check("fmul_hold_start", W'(iss_start), W'(0));
        idle(1'b1);
        check("fmul_retire", W'(iss_valid), W'(0));

        // Fill while busy, refuse a fifth, then drain back-to-back.
        for (int t = 1; t <= 5; t++) enq(FMUL, 32'(t), 32'(t + 100), 32'(t + 200), TAG_W'(t));
        check("full_count", W'(count), W'(4));
        check("full_ready", W'(enq_ready), W'(0));
        enq(FMUL, 32'h6, 32'h6, 32'h6, 5'd6);
        check("full_reject", W'(count), W'(4));
        for (int i = 0; i < 5; i++) begin
            idle(1'b1);
            if (i < 4) begin
                check("drain_start", W'(iss_start), W'(1));
                check("drain_tag", W'(iss_tag), W'(i + 2));
            end else begin
                check("drain_idle", W'(iss_valid), W'(0));
            end
        end
        check("drain_count", W'(count), W'(0));

        // FMADD: static rounding mode, third operand.
        frm = 3'b011;
        enq(FMADD, 32'h3F800000, 32'h40000000, 32'hBF800000, 5'd7);
        idle(1'b0);
        check("fmadd_rs3", W'(iss_rs3), W'(32'hBF800000));
        check("fmadd_rm", W'(iss_rm), W'(3'b000));
        idle(1'b1);

        // Enqueue and retire in the same cycle with two queued.
        for (int t = 8; t <= 10; t++) enq(FMUL, 32'(t), 32'(t), 32'(t), TAG_W'(t));
        check("sim_pre_count", W'(count), W'(2));
        check("sim_pre_tag", W'(iss_tag), W'(8));
        step(1'b1, FMUL, 32'd11, 32'd11, 32'd11, 5'd11, 1'b1, 1'b0);
        check("sim_count", W'(count), W'(2));
        check("sim_start", W'(iss_start), W'(1));
        check("sim_tag", W'(iss_tag), W'(9));
        idle(1'b0);
        check("sim_one_pulse", W'(iss_start), W'(0));
        repeat (3) idle(1'b1);
        check("sim_drained", W'(iss_valid), W'(0));

        // Flush while busy with three queued and an enqueue offered.
        for (int t = 12; t <= 15; t++) enq(FMUL, 32'(t), 32'(t), 32'(t), TAG_W'(t));
        check("flush_pre_count", W'(count), W'(3));
        step(1'b1, FMUL, 32'd16, 32'd16, 32'd16, 5'd16, 1'b0, 1'b1);
        check("flush_valid", W'(iss_valid), W'(0));
        check("flush_count", W'(count), W'(0));
        check("flush_start", W'(iss_start), W'(0));
        idle(1'b1);
        check("flush_done_valid", W'(iss_valid), W'(0));
        check("flush_done_count", W'(count), W'(0));
        enq(FMUL, 32'd17, 32'd17, 32'd17, 5'd17);
        idle(1'b0);
        check("post_flush_valid", W'(iss_valid), W'(1));
        check("post_flush_tag", W'(iss_tag), W'(17));
        idle(1'b1);

        // Random traffic with small occupancy to exercise pointer wrap.
        frm = 3'($urandom_range(0, 4));
        for (int i = 0; i < 60; i++) begin
            logic ev, dn;
            ev = (exp_q.size() < 3) && ($urandom_range(0, 3) != 0);
            dn = iss_valid && ($urandom_range(0, 2) != 0);
            step(ev, $urandom, $urandom, $urandom, $urandom, TAG_W'(i), dn, 1'b0);
        end
        repeat (8) idle(iss_valid);
        check("final_empty", W'(exp_q.size()), W'(0));
        check("final_idle", W'(iss_valid), W'(0));

        mon_en = 1'b0;
        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule

// File: doc/fp_issue_queue.md
# fp_issue_queue

In-order issue queue for the floating-point unit, three operands per entry. It buffers decoded FP instructions with their operand values (rs1/rs2/rs3) and presents one instruction at a time to the FPU. Its issue register holds that instruction's operands stable for the whole multicycle execution, until the FPU reports completion. It sits between the FP register-read stage and the FPU, and is the three-operand path needed by FMADD/FMSUB/FNMADD/FNMSUB.

## Interface
- DEPTH, 4, queue entries; power of two, 2..16
- FLEN, 32, operand width
- TAG_W, 5, destination tag width, passed through unchanged
- clk  in  1  clock
- resetn  in  1  reset, synchronous, active-low
- flush  in  1  discard all queued and in-flight state
- enq_valid  in  1  upstream offers an instruction
- enq_ready  out  1  queue can accept; enqueue happens when enq_valid & enq_ready
- enq_instr  in  32  raw instruction word
- enq_rs1, enq_rs2, enq_rs3  in  FLEN each  operand values
- enq_tag  in  TAG_W  destination tag
- frm  in  3  dynamic rounding mode, taken from fcsr[7:5]
- iss_valid  out  1  issue register holds an in-flight instruction
- iss_start  out  1  one-cycle pulse on the first cycle of each issued instruction
- iss_instr  out  32  issued instruction word
- iss_rs1, iss_rs2, iss_rs3  out  FLEN each  issued operands
- iss_tag  out  TAG_W  issued tag
- iss_rm  out  3  resolved rounding mode
- fpu_done  in  1  FPU result valid; retires the in-flight instruction
- count  out  $clog2(DEPTH)+1  occupancy of the queue, excluding the issue register

## Operation
- Storage: circular FIFO with head and tail pointers of $clog2(DEPTH) bits that wrap modulo DEPTH, plus a registered occupancy count.
- enq_ready = (count != DEPTH).
  - It depends only on registered state.
  - When the queue is full, a pop in the same cycle does not let an enqueue in.
- Rounding-mode resolution at issue: iss_rm = frm if instr[14:12] == 3'b111, else instr[14:12]. frm is sampled in the cycle the instruction is loaded into the issue register.
- State machine with two states:
  - IDLE: iss_valid = 0. If count != 0: load the head entry into the issue register, pop it, set iss_start, go to BUSY.
  - BUSY: iss_valid = 1 and all iss_* outputs are held constant.
    - On fpu_done with count != 0: load the next head, pop it, pulse iss_start, stay in BUSY. This is back-to-back issue.
    - On fpu_done with count == 0: go to IDLE.
  - fpu_done in IDLE is ignored.
- Simultaneous enqueue and pop: count is unchanged, and both pointers advance.
- flush has priority over everything else, including an enqueue in the same cycle.
  - It clears count and both pointers.
  - Next state is IDLE, with iss_valid = 0 and iss_start = 0.
  - The enqueue offered in that cycle is dropped, although enq_ready may read 1.
- Reset mid-operation: same effect as flush, applied at the reset edge. In-flight and queued entries are lost.

## Timing
- Reset values:
  - enq_ready = 1, count = 0, iss_valid = 0, iss_start = 0.
  - iss_instr, iss_rs1/2/3, iss_tag and iss_rm = 0.
  - State = IDLE.
- Enqueue-to-issue latency with FPQ_BYPASS_EN undefined:
  - Enqueue at edge N into an empty queue.
  - The IDLE load happens at edge N+1, so iss_valid and iss_start are high in the cycle after edge N+1.
- Retire-to-next-issue latency: fpu_done sampled at edge M with count != 0 means the new operands and iss_start are visible after edge M, with no bubble.
- iss_start is high for exactly one cycle per issued instruction and is never high while iss_valid = 0.
- The iss_* outputs change only at an issue edge, a flush or a reset.

## Configuration
- FPQ_BYPASS_EN defined:
  - Condition: state IDLE, count == 0, enq_valid = 1 and flush = 0.
  - The enqueued instruction goes directly into the issue register at the same edge, without entering the FIFO.
  - count stays 0, and iss_valid/iss_start are high after edge N. Latency is 1 cycle.
- FPQ_BYPASS_EN undefined: every instruction passes through the FIFO, and the minimum latency is 2 edges.

## Test plan
- Reset, then a single enqueue: fmul with instr funct3 = 3'b111, frm = 3'b010, rs1 = 0x40400000, rs2 = 0x40000000.
  - Required: iss_valid and iss_start rise 2 cycles later (1 cycle with FPQ_BYPASS_EN).
  - Required: iss_rm = 3'b010, and the operands hold until fpu_done, after which iss_valid = 0.
- Fill to DEPTH = 4 while the issue register is BUSY and fpu_done is held at 0.
  - Required: count = 4 and enq_ready = 0, and a 5th enq_valid is not accepted.
  - Then pulse fpu_done 5 times. Required: entries issue in FIFO order (tags 1..5) with no bubbles, and count returns to 0.
- Wrap-around: 10 enqueue/retire cycles with the occupancy alternating 1..3.
  - Required: tags issue in order, and count matches a scoreboard every cycle.
- Simultaneous enqueue and fpu_done with count = 2.
  - Required: count stays 2, the next head issues, and iss_start pulses once.
- FMADD entry with rs3 = 0xBF800000 and instr funct3 = 3'b000.
  - Required: iss_rs3 = 0xBF800000, and iss_rm = 3'b000 regardless of frm.
- flush asserted while BUSY with count = 3 and enq_valid = 1 in the same cycle.
  - Required next cycle: iss_valid = 0, count = 0, and no iss_start.
  - Required: a later fpu_done has no effect, and the next enqueue issues normally.
